// File: rtl/ripple_adder16.sv
// Unsigned WIDTH-bit ripple-carry adder built from an explicit chain of full-adder
// cells, with sum, carry vector, carry-out and zero-extended total registered.
module ripple_adder16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   c,
   output logic [WIDTH-1:0]   sum,
   output logic               carry,
   output logic [WIDTH+1:0]   sum_final
);

   localparam int unsigned SFW = WIDTH + 2;

   logic [WIDTH-1:0] sum_d, c_d;
   logic             carry_d;
   logic [SFW-1:0]   sum_final_d;

   logic [WIDTH-1:0] sum_q, c_q;
   logic             carry_q;
   logic [SFW-1:0]   sum_final_q;

   // Each cell owns its carry-out net so the chain is a true per-cell ripple
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic cin;
      logic prop;
      logic cout;

      if (i == 0) begin : g_lsb
         assign cin = 1'b0;
      end else begin : g_upper
         assign cin = g_cell[i-1].cout;
      end

      assign prop     = a[i] ^ b[i];
      assign sum_d[i] = prop ^ cin;
      assign cout     = (a[i] & b[i]) | (prop & cin);
      assign c_d[i]   = cout;
   end

   assign carry_d     = c_d[WIDTH-1];
   assign sum_final_d = {1'b0, carry_d, sum_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         c_q         <= '0;
         carry_q     <= 1'b0;
         sum_final_q <= '0;
      end else begin
         sum_q       <= sum_d;
         c_q         <= c_d;
         carry_q     <= carry_d;
         sum_final_q <= sum_final_d;
      end
   end

   assign sum       = sum_q;
   assign c         = c_q;
   assign carry     = carry_q;
   assign sum_final = sum_final_q;

endmodule

// File: tb/tb_ripple_adder16.sv
// Self-checking bench for ripple_adder16: expected results are queued when
// operands are driven and popped one edge later when the registered outputs appear.
module tb_ripple_adder16;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NRAND = 10000;

   typedef struct {
      logic [WIDTH-1:0] c;
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic [WIDTH+1:0] sum_final;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic [WIDTH-1:0]   a, b;
   logic [WIDTH-1:0]   c, sum;
   logic               carry;
   logic [WIDTH+1:0]   sum_final;

   int unsigned n_cmp;
   int unsigned n_err;
   exp_t        sb[$];

   ripple_adder16 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c         (c),
      .sum       (sum),
      .carry     (carry),
      .sum_final (sum_final)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: the carry out of bit i is bit i+1 of the sum of the low i+1 bits
   function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      exp_t        r;
      int unsigned tot;
      tot         = 32'(av) + 32'(bv);
      r.sum       = tot[WIDTH-1:0];
      r.carry     = tot[WIDTH];
      r.sum_final = (WIDTH+2)'(tot);
      for (int i = 0; i < int'(WIDTH); i++) begin
         int unsigned m, p;
         m = (32'h1 << (i + 1)) - 32'h1;
         p = (32'(av) & m) + (32'(bv) & m);
         r.c[i] = p[i+1];
      end
      return r;
   endfunction

   task automatic check_zero(input string tag);
      check_val({tag, ".c"},         32'(c),         32'h0);
      check_val({tag, ".sum"},       32'(sum),       32'h0);
      check_val({tag, ".carry"},     32'(carry),     32'h0);
      check_val({tag, ".sum_final"}, 32'(sum_final), 32'h0);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check_val({tag, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         check_val({tag, ".c"},         32'(c),         32'(e.c));
         check_val({tag, ".sum"},       32'(sum),       32'(e.sum));
         check_val({tag, ".carry"},     32'(carry),     32'(e.carry));
         check_val({tag, ".sum_final"}, 32'(sum_final), 32'(e.sum_final));
      end
   endtask

   // Drive one operand pair, push its expectation, take one edge, then check
   task automatic step(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
      a = av;
      b = bv;
      sb.push_back(model(av, bv));
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      a     = '0;
      b     = '0;

      // Held in reset with random operands and a running clock
      for (int i = 0; i < 4; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         @(posedge clk);
         #1;
         check_zero("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("post_release");

      // Directed vectors with known totals
      step(16'h9EFB, 16'hF318, "v9EFB_F318");
      check_val("v9EFB_F318.lit_sum",   32'(sum),       32'h9213);
      check_val("v9EFB_F318.lit_total", 32'(sum_final), 32'd102931);
      step(16'h9EFB, 16'hB318, "v9EFB_B318");
      check_val("v9EFB_B318.lit_total", 32'(sum_final), 32'd86547);
      step(16'hFEFB, 16'hF31E, "vFEFB_F31E");
      check_val("vFEFB_F31E.lit_total", 32'(sum_final), 32'd127513);
      step(16'hFFFF, 16'h0001, "ones_plus1");
      check_val("ones_plus1.lit_c",     32'(c),         32'h0000_FFFF);
      check_val("ones_plus1.lit_total", 32'(sum_final), 32'd65536);
      step(16'h0000, 16'h0000, "zero_zero");
      step(16'hFFFF, 16'hFFFF, "ones_ones");
      check_val("ones_ones.lit_total", 32'(sum_final), 32'h1FFFE);

      // Back-to-back then a reset pulse between edges drops the in-flight result
      step(16'h1234, 16'h4321, "b2b0");
      step(16'h8000, 16'h8000, "b2b1");
      a = 16'h7FFF;
      b = 16'h0001;
      sb.push_back(model(a, b));
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset_immediate");
      sb.delete();
      @(posedge clk);
      #1;
      check_zero("midreset_held");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("midreset_release");
      step(16'hA5A5, 16'h5A5B, "after_reset");

      // Random throughput run, one new operand pair per edge
      for (int i = 0; i < int'(NRAND); i++) begin
         step(WIDTH'($urandom), WIDTH'($urandom), "rand");
      end

      check_val("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
